// File: rtl/credit_fifo_rx.sv
// Receiver side of a credit-based link: DEPTH-entry FIFO with a valid/ready drain
// and one registered credit pulse returned per popped word.
module credit_fifo_rx #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_vld,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_vld,
   output logic [DATA_W-1:0] o_data,
   input  logic              i_ready,
   output logic              o_credit,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_ovf
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              pop;
   logic              wr_en;

   assign full  = (count == CNT_W'(DEPTH));
   assign o_vld = (count != '0);
   assign pop   = o_vld & i_ready;
   // When full, a push only lands if the head is leaving in the same cycle.
   assign wr_en = i_vld & (~full | pop);

   assign o_data  = mem[rd_ptr];
   assign o_count = count;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         o_credit <= 1'b0;
         o_ovf    <= 1'b0;
      end else begin
         o_credit <= pop;
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (wr_en && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !wr_en) begin
            count <= count - CNT_W'(1);
         end
         if (i_vld && full && !pop) begin
            o_ovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_credit_fifo_rx.sv
// Directed bench for credit_fifo_rx: fill/drain, full push+pop, overflow,
// full-rate wrap-around and asynchronous reset mid-operation.
module tb_credit_fifo_rx;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic              clk;
   logic              rst_n;
   logic              i_vld;
   logic [DATA_W-1:0] i_data;
   logic              o_vld;
   logic [DATA_W-1:0] o_data;
   logic              i_ready;
   logic              o_credit;
   logic [CNT_W-1:0]  o_count;
   logic              o_ovf;

   int checks = 0;
   int errors = 0;
   int credits_seen;

   credit_fifo_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_vld    (i_vld),
      .i_data   (i_data),
      .o_vld    (o_vld),
      .o_data   (o_data),
      .i_ready  (i_ready),
      .o_credit (o_credit),
      .o_count  (o_count),
      .o_ovf    (o_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      i_vld   = 1'b0;
      i_data  = '0;
      i_ready = 1'b0;
      tick();
      tick();
      chk("rst_count", 32'(o_count), 0);
      chk("rst_vld", 32'(o_vld), 0);
      chk("rst_credit", 32'(o_credit), 0);
      chk("rst_ovf", 32'(o_ovf), 0);
      rst_n = 1'b1;
      tick();

      // push 11,22,33 with no drain
      i_vld = 1'b1; i_data = 8'h11; tick();
      chk("t1_count1", 32'(o_count), 1);
      chk("t1_vld", 32'(o_vld), 1);
      chk("t1_head", 32'(o_data), 32'h11);
      chk("t1_credit1", 32'(o_credit), 0);
      i_data = 8'h22; tick();
      chk("t1_count2", 32'(o_count), 2);
      chk("t1_head2", 32'(o_data), 32'h11);
      i_data = 8'h33; tick();
      chk("t1_count3", 32'(o_count), 3);
      chk("t1_head3", 32'(o_data), 32'h11);
      chk("t1_credit3", 32'(o_credit), 0);
      i_vld = 1'b0;

      // drain them
      i_ready = 1'b1; tick();
      chk("d1_credit", 32'(o_credit), 1);
      chk("d1_data", 32'(o_data), 32'h22);
      tick();
      chk("d2_credit", 32'(o_credit), 1);
      chk("d2_data", 32'(o_data), 32'h33);
      tick();
      chk("d3_credit", 32'(o_credit), 1);
      chk("d3_count", 32'(o_count), 0);
      chk("d3_vld", 32'(o_vld), 0);
      i_ready = 1'b0; tick();
      chk("d4_credit", 32'(o_credit), 0);

      // fill A0..A3 then drain 4 cycles
      i_vld = 1'b1;
      for (int k = 0; k < 4; k++) begin
         i_data = 8'hA0 + 8'(k); tick();
      end
      i_vld = 1'b0;
      chk("t2_full", 32'(o_count), 4);
      i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("t2_vld", 32'(o_vld), 1);
         chk("t2_data", 32'(o_data), 32'hA0 + 32'(k));
         tick();
         chk("t2_credit", 32'(o_credit), 1);
         chk("t2_count", 32'(o_count), 32'(3 - k));
      end
      chk("t2_vld_end", 32'(o_vld), 0);
      i_ready = 1'b0; tick();
      chk("t2_credit_end", 32'(o_credit), 0);

      // full with simultaneous push 55 and pop
      i_vld = 1'b1;
      for (int k = 0; k < 4; k++) begin
         i_data = 8'hB0 + 8'(k); tick();
      end
      chk("t3_full", 32'(o_count), 4);
      i_data = 8'h55; i_ready = 1'b1;
      chk("t3_head", 32'(o_data), 32'hB0);
      tick();
      i_vld = 1'b0;
      chk("t3_count", 32'(o_count), 4);
      chk("t3_ovf", 32'(o_ovf), 0);
      chk("t3_credit", 32'(o_credit), 1);
      begin
         logic [7:0] exp3 [4];
         exp3[0] = 8'hB1; exp3[1] = 8'hB2; exp3[2] = 8'hB3; exp3[3] = 8'h55;
         for (int k = 0; k < 4; k++) begin
            chk("t3_data", 32'(o_data), 32'(exp3[k]));
            tick();
         end
      end
      chk("t3_empty", 32'(o_count), 0);
      i_ready = 1'b0; tick();

      // full, push 66 without pop -> dropped, sticky overflow
      i_vld = 1'b1;
      for (int k = 0; k < 4; k++) begin
         i_data = 8'hC0 + 8'(k); tick();
      end
      i_data = 8'h66; tick();
      i_vld = 1'b0;
      chk("t4_ovf", 32'(o_ovf), 1);
      chk("t4_count", 32'(o_count), 4);
      chk("t4_credit", 32'(o_credit), 0);
      chk("t4_head", 32'(o_data), 32'hC0);
      tick();
      chk("t4_ovf_hold", 32'(o_ovf), 1);
      i_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("t4_data", 32'(o_data), 32'hC0 + 32'(k));
         tick();
      end
      chk("t4_no66", 32'(o_vld), 0);
      chk("t4_ovf_sticky", 32'(o_ovf), 1);
      i_ready = 1'b0; tick();

      // wrap-around at full rate
      credits_seen = 0;
      i_ready = 1'b1; i_vld = 1'b1;
      for (int k = 0; k < 10; k++) begin
         i_data = 8'hD0 + 8'(k); tick();
         chk("t5_vld", 32'(o_vld), 1);
         chk("t5_data", 32'(o_data), 32'hD0 + 32'(k));
         chk("t5_count", 32'(o_count), 1);
         chk("t5_credit", 32'(o_credit), (k > 0) ? 1 : 0);
         if (o_credit) credits_seen++;
      end
      i_vld = 1'b0; tick();
      if (o_credit) credits_seen++;
      chk("t5_empty", 32'(o_count), 0);
      chk("t5_credits", 32'(credits_seen), 10);
      i_ready = 1'b0; tick();

      // async reset with count=3 and a pop in progress
      i_vld = 1'b1;
      for (int k = 0; k < 3; k++) begin
         i_data = 8'hE0 + 8'(k); tick();
      end
      i_vld = 1'b0;
      chk("t6_count", 32'(o_count), 3);
      i_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_count", 32'(o_count), 0);
      chk("t6_rst_vld", 32'(o_vld), 0);
      chk("t6_rst_credit", 32'(o_credit), 0);
      chk("t6_rst_ovf", 32'(o_ovf), 0);
      tick();
      i_ready = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("t6_post_credit", 32'(o_credit), 0);
      chk("t6_post_count", 32'(o_count), 0);
      i_vld = 1'b1; i_data = 8'hF1; tick();
      i_vld = 1'b0;
      chk("t6_push_vld", 32'(o_vld), 1);
      chk("t6_push_data", 32'(o_data), 32'hF1);
      chk("t6_push_count", 32'(o_count), 1);
      i_ready = 1'b1; tick();
      chk("t6_pop_credit", 32'(o_credit), 1);
      chk("t6_pop_count", 32'(o_count), 0);
      i_ready = 1'b0; tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/credit_fifo_rx.md
# credit_fifo_rx

Receiver end of the credit-based flow-control link. Buffers words pushed by a credit-counting transmitter into a DEPTH-entry FIFO and delivers them downstream over a valid/ready handshake. Returns exactly one credit pulse per word popped; the pulse drives the transmitter's credit-increment input. Sits at the input of each systolic-array row/column feeder. The transmitter is sized with MAX_CREDITS = DEPTH.

## Interface
- DATA_W, 8, payload width in bits
- DEPTH, 4, FIFO entries; power of two, ≥2; must equal the transmitter's credit count
- PTR_W, $clog2(DEPTH), read/write pointer width
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (holds 0..DEPTH)

- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_vld  in  1  transmitter push strobe; no backpressure path, since credits guarantee space
- i_data  in  DATA_W  push payload, sampled when i_vld=1
- o_vld  out  1  head entry valid (FIFO not empty)
- o_data  out  DATA_W  head entry payload; held stable while o_vld=1 and i_ready=0
- i_ready  in  1  downstream accepts head
- o_credit  out  1  one-cycle credit-return pulse, registered
- o_count  out  CNT_W  current occupancy, 0..DEPTH
- o_ovf  out  1  sticky overflow error (push while full with no pop)

## Operation
- push = i_vld. pop = o_vld & i_ready.
- Storage: DEPTH×DATA_W register array with write pointer wr_ptr and read pointer rd_ptr. Both are PTR_W bits and wrap naturally modulo DEPTH. count is CNT_W bits.
- Push when not full: mem[wr_ptr] <= i_data, wr_ptr++.
- Pop: rd_ptr++.
- count update:
  - push only: +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
- Full (count==DEPTH), push and pop in the same cycle: accepted. Write lands in the slot being freed, and count stays DEPTH.
- Full, push without pop: the word is dropped. Pointers and count are unchanged, and o_ovf is set. o_ovf holds until reset.
- Empty (count==0): o_vld=0, and i_ready is ignored.
- Empty with a push: no fall-through. The word appears at o_vld the next cycle.
- o_data = mem[rd_ptr]. Its value is don't-care while o_vld=0.
- Credit return: o_credit <= pop, registered. There is exactly one pulse per popped word and no pulse for dropped words. Back-to-back pops give back-to-back pulses.
- Reset values (asynchronous, immediate):
  - wr_ptr, rd_ptr, count, o_credit, o_ovf = 0
  - o_vld = 0
  - memory contents are not reset
- Reset mid-operation discards all stored words and in-flight credits. The transmitter's counter is reset by the same rst_n back to DEPTH, so the link is consistent after release.

## Timing
- Push-to-output latency: 1 cycle. A word pushed at edge N is visible on o_vld/o_data after edge N.
- Pop-to-credit latency: 1 cycle. A pop sampled at edge N gives o_credit=1 for the cycle after edge N, and the transmitter counts it at edge N+1.
- Round trip at full rate: sustained 1 word/cycle is possible with DEPTH ≥ 2 and i_ready held high.
- o_count, o_vld and o_ovf are registered or decoded from registered state. No combinational path from i_vld or i_data to any output.
- o_credit has no combinational path from i_ready.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with i_ready=0:
  - o_count goes 1, 2, 3.
  - o_data=0x11 with o_vld=1 from the cycle after the first push.
  - o_credit stays 0.
- Fill to 4 (0xA0..0xA3), then i_ready=1 for 4 cycles:
  - o_data sequence is A0, A1, A2, A3.
  - o_credit pulses on 4 consecutive cycles, each lagging its pop by 1.
  - o_count reaches 0 and o_vld drops.
- Full, plus a simultaneous push 0x55 and pop:
  - o_count stays 4 and o_ovf stays 0.
  - 0x55 emerges after the 3 older words.
  - One credit pulse.
- Full, push 0x66 with i_ready=0:
  - o_ovf=1 and stays set.
  - o_count stays 4 and 0x66 never appears.
  - No credit pulse.
- Wrap-around: 10 words pushed at 1/cycle with i_ready=1 continuously.
  - All 10 words emerge in order, each at 1-cycle latency.
  - o_count never exceeds 1.
  - 10 credit pulses.
- Assert rst_n=0 asynchronously with count=3 and a pop in progress:
  - All outputs zero immediately, and no credit pulse after release.
  - The next push after release reappears normally.
